multdiv: RTL and testbench
==========================

Name: multdiv

Overview:
- Multi-cycle signed 32-bit multiply/divide unit in the execute stage, beside the single-cycle ALU.
- Fed from the same D/X operand latches as the ALU.
- Result and exception flag are consumed by the X/M latch through the writeback-select mux.
- The pipeline stalls from start until data_resultRDY.

Parameters:
- WIDTH, 32, operand/result width; multiply iteration count is WIDTH/2 and divide iteration count is WIDTH.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  reset; asynchronous assert, active-low.
- data_operandA  in  WIDTH  multiplicand / dividend; sampled only in the start cycle.
- data_operandB  in  WIDTH  multiplier / divisor; sampled only in the start cycle.
- ctrl_MULT  in  1  start-multiply pulse.
- ctrl_DIV  in  1  start-divide pulse.
- data_result  out  WIDTH  low WIDTH bits of the product, or the quotient.
- data_exception  out  1  overflow / divide-by-zero flag; valid with data_resultRDY.
- data_resultRDY  out  1  one-cycle pulse: result valid.
- busy  out  1  high from the edge after start through the cycle before data_resultRDY.

Behaviour:
- Reset: state=IDLE; data_result=0, data_exception=0, data_resultRDY=0, busy=0; all internal registers cleared.
- Reset asserted mid-operation aborts immediately; no data_resultRDY is produced.
- States: IDLE, MULT, DIV, DONE.
  - IDLE -> MULT when ctrl_MULT=1 at an edge.
  - IDLE -> DIV when ctrl_DIV=1 at an edge.
  - MULT -> DONE after 16 iterations.
  - DIV -> DONE after 32 iterations.
  - DONE -> IDLE unconditionally.
- Start edge: operands are latched, the iteration counter is cleared, busy=1 and data_resultRDY=0.
- Start handling:
  - A start in any state, including mid-operation or DONE, aborts the current operation and restarts with the new operands.
  - ctrl_MULT and ctrl_DIV both high: multiply wins and ctrl_DIV is ignored.
- Multiply:
  - Radix-4 modified Booth, one recoded digit (0, +-A, +-2A) per cycle.
  - 65-bit product/multiplier register; 16 iterations.
  - data_resultRDY is high in the cycle after the 17th edge counted from the start edge (start edge = edge 0).
  - data_result = product[31:0].
  - data_exception=1 iff product[63:31] are not all equal (signed overflow).
- Divide:
  - Non-restoring division on magnitudes, 32 iterations plus a final remainder-correction/sign-fix cycle.
  - data_resultRDY is high in the cycle after the 33rd edge counted from the start edge.
  - Quotient is truncated toward zero; quotient sign = signA XOR signB; remainder is discarded.
  - Divisor = 0: data_result=0, data_exception=1.
  - 0x80000000 / 0xFFFFFFFF: data_result=0x80000000, data_exception=1.
- data_resultRDY is high for exactly one cycle, in state DONE.
- data_result and data_exception hold their values until the next start edge.
- Operand inputs may change freely after the start edge; only the latched copies are used.

Optional Feature:
- Macro: MULTDIV_EARLY_OUT_EN.
- Defined:
  - Divisor = 0 at start goes straight to DONE; data_resultRDY follows edge 1 with result 0 and exception 1.
  - Either multiply operand = 0 at start goes straight to DONE; data_resultRDY follows edge 1 with result 0 and exception 0.
- Undefined: these cases take the full 17/33-edge latency with the same result values.

Decomposition:
- Package multdiv_pkg holds:
  - state enum {IDLE, MULT, DIV, DONE};
  - MULT_ITERS=16 and DIV_ITERS=32;
  - Booth digit encoding constants.
- One sub-module, booth_recoder: combinational mapping of a 3-bit multiplier window to {zero, negate, double}.
- The divide step stays inline in the top module.

Test Plan:
- Multiply sign and overflow cases:
  - ctrl_MULT, A=7, B=-3 -> data_resultRDY after edge 17, data_result=0xFFFFFFEB, exception=0.
  - A=0x10000, B=0x10000 -> result=0, exception=1.
- Divide rounding and zero divisor:
  - ctrl_DIV, A=-7, B=2 -> data_resultRDY after edge 33, result=0xFFFFFFFD (-3), exception=0.
  - A=5, B=0 -> result=0, exception=1.
- Divide overflow: A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1; multiply of the same operands -> result=0x80000000, exception=1.
- Restart and priority:
  - ctrl_MULT, then ctrl_DIV 5 cycles later with A=100, B=7 -> exactly one data_resultRDY, 33 edges after the DIV start, result=14.
  - ctrl_MULT and ctrl_DIV in the same cycle -> multiply result.
- Reset: reset_n low at iteration 10 of a divide -> all outputs 0 asynchronously; no data_resultRDY after release; next start behaves normally.
- MULTDIV_EARLY_OUT_EN defined: A=9, B=0 divide -> data_resultRDY after edge 1, exception=1. Undefined -> data_resultRDY after edge 33, same values.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the multiply/divide unit: FSM states,
// iteration counts and the radix-4 Booth digit encoding.
package multdiv_pkg;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  localparam int MULT_ITERS = 16;
  localparam int DIV_ITERS  = 32;

  // One recoded Booth digit: 0, +-A or +-2A
  typedef struct packed {
    logic zero;
    logic neg;
    logic dbl;
  } booth_t;

  localparam booth_t BOOTH_ZERO = 3'b100;
  localparam booth_t BOOTH_POS1 = 3'b000;
  localparam booth_t BOOTH_POS2 = 3'b001;
  localparam booth_t BOOTH_NEG1 = 3'b010;
  localparam booth_t BOOTH_NEG2 = 3'b011;

endpackage

// File: rtl/multdiv_booth_recoder.sv
// Radix-4 modified Booth recoder: maps a 3-bit multiplier window
// {b[i+1], b[i], b[i-1]} onto a signed digit in {0, +-1, +-2}.
module booth_recoder
  import multdiv_pkg::*;
(
  input  logic [2:0] win,
  output booth_t     dig
);

  always_comb begin
    dig = BOOTH_ZERO;
    case (win)
      3'b001, 3'b010: dig = BOOTH_POS1;
      3'b011:         dig = BOOTH_POS2;
      3'b100:         dig = BOOTH_NEG2;
      3'b101, 3'b110: dig = BOOTH_NEG1;
      default:        dig = BOOTH_ZERO;
    endcase
  end

endmodule

// File: rtl/multdiv.sv
// Multi-cycle signed multiply (radix-4 Booth) / divide (non-restoring) unit.
// Optional MULTDIV_EARLY_OUT_EN finishes zero-operand / zero-divisor cases after one iteration slot.
module multdiv
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int M_IT = MULT_ITERS * WIDTH / 32;
  localparam int D_IT = DIV_ITERS * WIDTH / 32;
  localparam int CW   = $clog2(WIDTH) + 1;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [WIDTH-1:0]     a_reg;
  logic [2*WIDTH:0]     prod;
  logic [WIDTH-1:0]     dvsr;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH+1:0]     rem;
  logic                 q_neg;
  logic                 dvz;
  logic                 start;
  logic                 mul_early;
  logic                 div_early;

  assign start = ctrl_MULT | ctrl_DIV;

  // ---- multiply datapath ----
  booth_t dig;
  booth_recoder u_rec (.win(prod[2:0]), .dig(dig));

  logic signed [WIDTH+1:0] a_ext, pp_mag, pp, psum;
  logic [2*WIDTH:0]        prod_nxt;
  logic [2*WIDTH-1:0]      product;
  logic                    mul_ovf;

  always_comb begin
    a_ext  = {{2{a_reg[WIDTH-1]}}, a_reg};
    pp_mag = dig.dbl ? {a_ext[WIDTH:0], 1'b0} : a_ext;
    pp     = dig.zero ? '0 : (dig.neg ? -pp_mag : pp_mag);
    // Upper half is summed two bits wider so +-2A never overflows before the shift
    psum   = $signed({{2{prod[2*WIDTH]}}, prod[2*WIDTH:WIDTH+1]}) + pp;
  end

  assign prod_nxt = {psum, prod[WIDTH:2]};
  assign product  = prod[2*WIDTH:1];
  assign mul_ovf  = ~(&product[2*WIDTH-1:WIDTH-1] | ~|product[2*WIDTH-1:WIDTH-1]);

  // ---- divide datapath (magnitudes, remainder kept signed) ----
  logic [WIDTH+1:0] rem_sh, rem_nxt;
  logic [WIDTH-1:0] quo_nxt, quo_fix, abs_a, abs_b;
  logic             div_ovf;

  always_comb begin
    rem_sh  = {rem[WIDTH:0], quo[WIDTH-1]};
    rem_nxt = rem[WIDTH+1] ? rem_sh + {2'b00, dvsr} : rem_sh - {2'b00, dvsr};
    quo_nxt = {quo[WIDTH-2:0], ~rem_nxt[WIDTH+1]};
    quo_fix = q_neg ? -quo : quo;
    div_ovf = ~q_neg & quo[WIDTH-1];
    abs_a   = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    abs_b   = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
  end

`ifdef MULTDIV_EARLY_OUT_EN
  logic mul_zero;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)   mul_zero <= 1'b0;
    else if (start) mul_zero <= (data_operandA == '0) || (data_operandB == '0);
  end
  assign mul_early = mul_zero;
  assign div_early = dvz;
`else
  assign mul_early = 1'b0;
  assign div_early = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      cnt            <= '0;
      a_reg          <= '0;
      prod           <= '0;
      dvsr           <= '0;
      quo            <= '0;
      rem            <= '0;
      q_neg          <= 1'b0;
      dvz            <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else if (start) begin
      cnt            <= '0;
      busy           <= 1'b1;
      data_resultRDY <= 1'b0;
      if (ctrl_MULT) begin
        state <= MULT;
        a_reg <= data_operandA;
        prod  <= {{WIDTH{1'b0}}, data_operandB, 1'b0};
      end else begin
        state <= DIV;
        dvsr  <= abs_b;
        quo   <= abs_a;
        rem   <= '0;
        q_neg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        dvz   <= (data_operandB == '0);
      end
    end else begin
      case (state)
        MULT: begin
          if (mul_early || cnt == CW'(M_IT)) begin
            state          <= DONE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            data_result    <= mul_early ? '0 : product[WIDTH-1:0];
            data_exception <= ~mul_early & mul_ovf;
          end else begin
            prod <= prod_nxt;
            cnt  <= cnt + 1'b1;
          end
        end
        DIV: begin
          // Last slot is the sign fix; the remainder is discarded so it is never corrected
          if (div_early || cnt == CW'(D_IT)) begin
            state          <= DONE;
            busy           <= 1'b0;
            data_resultRDY <= 1'b1;
            data_result    <= dvz ? '0 : quo_fix;
            data_exception <= dvz | div_ovf;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state          <= IDLE;
          data_resultRDY <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv.sv
// Self-checking bench for multdiv: table of vectors plus random model-checked
// operations, then restart, priority and mid-operation reset sequences.
module tb_multdiv;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  multdiv #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always #5 clock = ~clock;

`ifdef MULTDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  typedef struct {
    logic        mult;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   ncmp = 0;
  int   nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic mult, input logic [31:0] a, input logic [31:0] b);
    logic z;
    z = mult ? (a == 0 || b == 0) : (b == 0);
    return (EARLY && z) ? 1 : (mult ? 17 : 33);
  endfunction

  task automatic model(input logic mult, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic e);
    logic signed [63:0] p;
    logic [32:0]        hi;
    if (mult) begin
      p  = 64'($signed(a)) * 64'($signed(b));
      r  = p[31:0];
      hi = p[63:31];
      e  = !(hi == '0 || hi == '1);
    end else if (b == 0) begin
      r = '0; e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000; e = 1'b1;
    end else begin
      r = $signed(a) / $signed(b);
      e = 1'b0;
    end
  endtask

  // Drives one start pulse; returns #1 after the start edge (edge 0)
  task automatic start(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT = m; ctrl_DIV = d;
    data_operandA = a; data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
    data_operandA = $urandom; data_operandB = $urandom;
  endtask

  task automatic wait_rdy(output int n, output bit ok);
    n = 0; ok = 1'b0;
    repeat (100) begin
      @(posedge clock);
      n++;
      @(negedge clock);
      if (data_resultRDY) begin ok = 1'b1; break; end
    end
  endtask

  task automatic finish_op(input string name);
    int   n;
    bit   ok;
    exp_t e;
    wait_rdy(n, ok);
    chk({name, " ready"}, 32'(ok), 32'd1);
    if (ok && sb.size() != 0) begin
      e = sb.pop_front();
      chk({name, " result"}, data_result, e.res);
      chk({name, " exc"}, 32'(data_exception), 32'(e.exc));
      chk({name, " latency"}, n, e.lat);
      chk({name, " busy@rdy"}, 32'(busy), 32'd0);
      @(negedge clock);
      chk({name, " rdy pulse"}, 32'(data_resultRDY), 32'd0);
      chk({name, " hold"}, data_result, e.res);
    end
  endtask

  task automatic do_op(input string name, input logic m, input logic d,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input logic e);
    exp_t x;
    x.res = r; x.exc = e; x.lat = exp_lat(m, a, b);
    sb.push_back(x);
    start(m, d, a, b);
    chk({name, " busy@start"}, 32'(busy), 32'd1);
    finish_op(name);
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] r, a, b;
    logic        e, m;
    int          extra;

    vecs = '{
      '{1'b1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0},
      '{1'b1, 32'h0001_0000,  32'h0001_0000, 32'h0000_0000, 1'b1},
      '{1'b0, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0},
      '{1'b0, 32'd5,          32'd0,         32'h0000_0000, 1'b1},
      '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1},
      '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1},
      '{1'b0, 32'd100,        32'd7,         32'd14,        1'b0},
      '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         1'b0},
      '{1'b0, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0},
      '{1'b0, 32'hFFFF_FFF8,  32'hFFFF_FFFE, 32'd4,         1'b0},
      '{1'b1, 32'd0,          32'd1234,      32'd0,         1'b0},
      '{1'b1, 32'h7FFF_FFFF,  32'd2,         32'hFFFF_FFFE, 1'b1},
      '{1'b1, 32'hFFFF_8000,  32'h0001_0000, 32'h8000_0000, 1'b0},
      '{1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0},
      '{1'b0, 32'h7FFF_FFFF,  32'h8000_0000, 32'd0,         1'b0},
      '{1'b0, 32'h8000_0000,  32'h8000_0000, 32'd1,         1'b0},
      '{1'b0, 32'd9,          32'd0,         32'd0,         1'b1}
    };

    // Reset state
    #12;
    chk("reset result", data_result, 32'd0);
    chk("reset exc", 32'(data_exception), 32'd0);
    chk("reset rdy", 32'(data_resultRDY), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), vecs[i].mult, ~vecs[i].mult,
            vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc);

    for (int i = 0; i < 8; i++) begin
      m = i[0];
      a = $urandom;
      b = (i < 4) ? $urandom : ($urandom_range(1, 1000) ^ {32{i[1]}});
      model(m, a, b, r, e);
      do_op($sformatf("rand%0d", i), m, ~m, a, b, r, e);
    end

    // Restart: a divide 5 edges into a multiply replaces it
    extra = 0;
    start(1'b1, 1'b0, 32'd3, 32'd5);
    repeat (4) begin
      @(negedge clock);
      if (data_resultRDY) extra++;
    end
    sb.push_back('{32'd14, 1'b0, 33});
    start(1'b0, 1'b1, 32'd100, 32'd7);
    finish_op("restart");
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) extra++;
    end
    chk("restart single rdy", extra, 0);

    // Both start pulses together: multiply wins
    do_op("priority", 1'b1, 1'b1, 32'd6, 32'd7, 32'd42, 1'b0);

    // Asynchronous reset during divide iteration 10
    start(1'b0, 1'b1, 32'd1000, 32'd3);
    repeat (10) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midreset result", data_result, 32'd0);
    chk("midreset exc", 32'(data_exception), 32'd0);
    chk("midreset rdy", 32'(data_resultRDY), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    extra = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) extra++;
    end
    chk("no rdy after reset", extra, 0);
    do_op("post reset", 1'b0, 1'b1, 32'd1000, 32'd3, 32'd333, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule
